// File: rtl/m_ext_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package m_ext_unit_pkg;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } m_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [4:0]  ITER_LAST  = 5'd31;

    // Two's-complement negate when neg is set; maps INT_MIN to itself,
    // which is also its correct unsigned magnitude.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/m_ext_unit_iter.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step, with a 5-bit step counter.
module m_ext_unit_iter
    import m_ext_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        last,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    // hi: product accumulator / partial remainder; lo: multiplier / quotient
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        div_q, div_d;

    logic [32:0] sum;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
        shifted = {hi_q, lo_q[31]};
        ge      = shifted >= {1'b0, opb_q};
        diff    = shifted[31:0] - opb_q;
        if (div_q) begin
            hi_nxt = ge ? diff : shifted[31:0];
            lo_nxt = {lo_q[30:0], ge};
        end else begin
            hi_nxt = sum[32:1];
            lo_nxt = {sum[0], lo_q[31:1]};
        end
    end

    assign last = (cnt_q == ITER_LAST);

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = op_a;
            opb_d = op_b;
            cnt_d = '0;
            div_d = is_div;
        end else if (step) begin
            hi_d  = hi_nxt;
            lo_d  = lo_nxt;
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/m_ext_unit.sv
// RV32M multiply/divide unit for the EX stage: sign conditioning, special-case
// shortcuts, control FSM and flush handling around the iterative core.
module m_ext_unit
    import m_ext_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    m_state_t    state_q, state_d;
    m_funct3_t   f3_q, f3_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;

    m_funct3_t   f3_in;
    logic        sgn1, sgn2, s1, s2;
    logic [31:0] mag_a, mag_b;
    logic        is_div_in, is_rem_in;
    logic        div0, ovf, special, accept;
    logic [31:0] special_res;

    logic        last;
    logic [31:0] hi_nxt, lo_nxt;
    logic [63:0] prod_s;
    logic [31:0] calc_res;

    assign f3_in = m_funct3_t'(funct3);

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        case (f3_in)
            M_MUL, M_MULH, M_DIV, M_REM: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            M_MULHSU: sgn1 = 1'b1;
            default: ;
        endcase
    end

    assign s1        = sgn1 & rs1_val[31];
    assign s2        = sgn2 & rs2_val[31];
    assign mag_a     = cond_neg(rs1_val, s1);
    assign mag_b     = cond_neg(rs2_val, s2);
    assign is_div_in = funct3[2];
    assign is_rem_in = funct3[2] & funct3[1];

    // Special cases bypass iteration and go straight to DONE
    assign div0    = is_div_in && (rs2_val == '0);
    assign ovf     = ((f3_in == M_DIV) || (f3_in == M_REM)) &&
                     (rs1_val == INT_MIN) && (rs2_val == '1);
    assign special = div0 | ovf;
    assign accept  = (state_q == IDLE) && start && !flush;

    always_comb begin
        if (div0)
            special_res = is_rem_in ? rs1_val : DIV_ZERO_Q;
        else
            special_res = is_rem_in ? 32'd0 : INT_MIN;
    end

    m_ext_unit_iter u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state_q == CALC),
        .is_div (is_div_in),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .last   (last),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Final sign fix-up uses the core's last-step values so the result lands with DONE
    always_comb begin
        prod_s = neg_q ? (~{hi_nxt, lo_nxt} + 64'd1) : {hi_nxt, lo_nxt};
        case (f3_q)
            M_MUL:                     calc_res = prod_s[31:0];
            M_MULH, M_MULHSU, M_MULHU: calc_res = prod_s[63:32];
            M_DIV, M_DIVU:             calc_res = cond_neg(lo_nxt, neg_q);
            default:                   calc_res = cond_neg(hi_nxt, neg_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush)
                    state_d = IDLE;
                else if (last)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE) && !flush;
    end

    always_comb begin
        f3_d     = f3_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (accept) begin
            f3_d  = f3_in;
            neg_d = is_rem_in ? s1 : (s1 ^ s2);
            if (special)
                result_d = special_res;
        end else if ((state_q == CALC) && !flush && last) begin
            result_d = calc_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q     <= M_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Directed bench for m_ext_unit with a result/latency scoreboard.
module tb_m_ext_unit;
    import m_ext_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        busy, done;
    logic [31:0] result;

    m_ext_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          bcy;
    } exp_t;

    exp_t  sb[$];
    string sb_nm[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    ncount = 0;
    int    t0 = 0;
    int    bcount = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: marks launch cycles, counts busy cycles, checks each done against the queue
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        ncount++;
        if (rst && start && !busy && !done && !flush) begin
            t0     = ncount;
            bcount = 0;
        end else if (busy) begin
            bcount++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e  = sb.pop_front();
                nm = sb_nm.pop_front();
                chk({nm, "_result"}, result, e.res);
                chk({nm, "_latency"}, ncount - t0, e.lat);
                chk({nm, "_busy_cycles"}, bcount, e.bcy);
            end
        end
    end

    task automatic issue(input m_funct3_t f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit special, input bit push,
                         input string nm);
        exp_t e;
        if (push) begin
            e.res = exp_res;
            e.lat = special ? 1 : 33;
            e.bcy = special ? 0 : 32;
            sb.push_back(e);
            sb_nm.push_back(nm);
            last_res = exp_res;
        end
        @(posedge clk);
        #1;
        funct3  = f3;
        rs1_val = a;
        rs2_val = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !busy && !done) return;
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
        sb.delete();
        sb_nm.delete();
    endtask

    task automatic run_op(input m_funct3_t f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit special, input string nm);
        issue(f3, a, b, exp_res, special, 1'b1, nm);
        wait_idle(nm);
    endtask

    initial begin
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_op(M_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        run_op(M_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, "mul_shift");
        run_op(M_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min");
        run_op(M_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh_m1_m1");
        run_op(M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        run_op(M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_max");
        run_op(M_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run_op(M_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        run_op(M_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7");
        run_op(M_REMU,   32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7");
        run_op(M_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, "divu_max_1");
        run_op(M_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div_by_zero");
        run_op(M_REMU,   32'd5,         32'd0,         32'd5,         1'b1, "remu_by_zero");
        run_op(M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_overflow");
        run_op(M_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, "rem_overflow");

        // Flush on the 10th CALC cycle: back to IDLE, no done, result untouched
        issue(M_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, "flushed");
        repeat (9) @(posedge clk);
        #1;
        chk("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result", result, last_res);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_result_late", result, last_res);

        // flush together with start in IDLE: start is dropped
        @(posedge clk);
        #1;
        funct3  = M_MUL;
        rs1_val = 32'd3;
        rs2_val = 32'd3;
        start   = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        chk("flush_start_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_start_result", result, last_res);

        // start during CALC is ignored; the original multiply completes
        issue(M_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1, "mul_start_in_calc");
        repeat (5) @(posedge clk);
        #1;
        funct3  = M_DIVU;
        rs1_val = 32'd9;
        rs2_val = 32'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("mul_start_in_calc");

        // Asynchronous reset mid-CALC abandons the operation
        issue(M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, "mulhu_reset");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        void'(sb.pop_back());
        void'(sb_nm.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_op(M_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, "divu_after_reset");
        repeat (3) @(posedge clk);
        #1;
        chk("final_result_hold", result, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/m_ext_unit.md
Name: m_ext_unit

Overview:
- Iterative RV32M multiply/divide unit instantiated inside the EX stage.
- Launched when the ID/EX control word has ex_ctrlwd.m_extension_act set.
- Consumes rs1_out/rs2_out and the funct3 field (m_funct3_t) and returns a 32-bit result to the EX/MEM alu_out path.
- While it runs, EX stalls the pipeline via busy.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  launch request; sampled only in IDLE
funct3  input  3  m_funct3_t operation select, captured with start
rs1_val  input  XLEN  operand A (dividend / multiplicand)
rs2_val  input  XLEN  operand B (divisor / multiplier)
flush  input  1  synchronous abort from branch-taken / pipeline flush
busy  output  1  high while in CALC; EX stalls on it
done  output  1  one-cycle pulse; result valid that cycle
result  output  XLEN  operation result; held until next accepted start

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. Reset mid-operation abandons the operation; no done is produced.
- States (m_state_t):
  - IDLE -> CALC on start when the operands are not a special case.
  - IDLE -> DONE on start when the operands are a special case.
  - CALC -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally.
- Start accept: start is accepted only in IDLE. On an accepted start, funct3, the operand magnitudes, the result-sign flags and the op class (mul/div) are registered.
- Start ignored: start in CALC or DONE is ignored.
- Operand signedness:
  - mul, mulh, div, rem: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - mulhu, divu, remu: both unsigned.
  - Signed operands are converted to magnitude before iteration.
- Multiply: radix-2 shift-add over a 64-bit product register, one bit per cycle, 32 cycles.
  - Product sign: s1^s2 for mul/mulh; s1 for mulhsu.
  - Negation is applied to the full 64 bits.
  - mul returns product[31:0]; mulh/mulhsu/mulhu return product[63:32].
- Divide: restoring divide, one quotient bit per cycle, 32 cycles; 33-bit partial-remainder subtraction.
  - Quotient sign: s1^s2. Remainder sign: s1 (sign of the dividend).
- Counter: 5-bit iteration counter, cleared on accept. CALC exits on the edge where the counter reads 31.
- Latency:
  - Normal op: start sampled at edge N; done high in the cycle after edge N+33. Busy is high for 32 cycles.
  - Special case: done high in the cycle after edge N+1 (DONE directly); busy never asserts.
- Special cases (decided at accept time, no iteration):
  - Divide by zero: div/divu -> 0xFFFFFFFF; rem/remu -> rs1_val.
  - Signed overflow (div/rem with rs1=0x80000000, rs2=0xFFFFFFFF): div -> 0x80000000; rem -> 0.
  - Multiply has no special cases.
- done: exactly one cycle, only in DONE. result is registered on entry to DONE and stays stable through IDLE until the next accepted start updates it.
- Flush:
  - In CALC or DONE: next state IDLE; done suppressed (forced 0 in that cycle if in DONE); result keeps its previous value.
  - flush and start together in IDLE: start is ignored.

Decomposition:
- rv32i_types (existing): m_funct3_t, already present; add m_state_t enum {IDLE, CALC, DONE} (logic [1:0]).
- Local constants: DIV_ZERO_Q = 32'hFFFFFFFF, INT_MIN = 32'h80000000.
- One sub-module, m_iter_core: unsigned shift-add/restoring datapath plus iteration counter, with a start/last-iteration interface. Sign conditioning, special-case detection, FSM and flush handling stay in m_ext_unit.

Test Plan:
- mul, rs1=7, rs2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 33 cycles after the start cycle; busy high 32 cycles.
- mulh 0x80000000*0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- div 0xFFFFFFF9/2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 100/7 -> 14; remu 100/7 -> 2.
- div 5/0 -> 0xFFFFFFFF and remu 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000 and rem -> 0; each with done one cycle after start and busy never high.
- Abort cases:
  - flush on the 10th CALC cycle -> IDLE next edge, no done, result unchanged.
  - start asserted during CALC -> ignored; the original op completes with its original result.
- rst pulled low mid-CALC -> busy/done/result read 0 immediately. A new divu 9/3 after release -> 3 at normal latency.
